// File: rtl/prog_loader.sv
// prog_loader: loads a program into a 256x9 instruction RAM, then holds the
// core out of reset while it runs until it halts or hits the cycle limit.
// Optional feature macro: CYCLE_CNT_EN builds the RUN cycle counter and the
// MAX_CYCLES timeout. Without it, cycle_cnt is tied to zero and err is set
// only by a program overflowing the RAM.
//
// Load handshake: a beat transfers on a rising edge where ld_valid and
// ld_ready are both high. ld_ready depends only on state (high in LOAD) and
// never on ld_valid. A beat with ld_last, or the beat written to the final
// address, ends the load.
//
// dbg_state encoding: 0 = IDLE, 1 = LOAD, 2 = RUN, 3 = HALT.
module prog_loader #(
    parameter logic [15:0] MAX_CYCLES = 16'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ld_valid,
    input  logic [8:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic [7:0]  pc,
    output logic [8:0]  inst,
    input  logic        core_done,
    output logic        core_reset,
    output logic        busy,
    output logic        finished,
    output logic        err,
    output logic [15:0] cycle_cnt,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  waddr_q;
    logic [8:0]  mem [0:255];
    logic        accept;
    logic        load_end;
    logic        session_start;
    logic        timeout;

    assign accept        = ld_valid & ld_ready;
    // The last address ends the load even without ld_last, so waddr never wraps.
    assign load_end      = accept & (ld_last | (waddr_q == 8'hFF));
    assign session_start = start & ((state_q == S_IDLE) | (state_q == S_HALT));

    assign ld_ready   = (state_q == S_LOAD);
    assign core_reset = (state_q != S_RUN);
    assign busy       = (state_q == S_LOAD) | (state_q == S_RUN);
    assign finished   = (state_q == S_HALT);
    assign dbg_state  = state_q;
    assign inst       = mem[pc];

    // Instruction RAM write port; reset aborts a beat but never clears contents.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem[waddr_q] <= ld_data;
        end
    end

`ifdef CYCLE_CNT_EN
    logic [15:0] cnt_q;

    // A RUN cycle at the limit without done ends the session as a timeout.
    assign timeout   = (state_q == S_RUN) & ~core_done & (cnt_q == MAX_CYCLES);
    assign cycle_cnt = cnt_q;

    // RUN cycle counter: cleared at session start, counts non-done RUN cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else if (session_start) begin
            cnt_q <= 16'd0;
        end else if ((state_q == S_RUN) && !core_done && !timeout) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    // No counter: the limit only feeds a constant-false timeout.
    assign timeout   = 1'b0 & (MAX_CYCLES != 16'd0);
    assign cycle_cnt = 16'd0;
`endif

    // State register and load address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            waddr_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (session_start) begin
                waddr_q <= 8'd0;
            end else if (accept && !load_end) begin
                waddr_q <= waddr_q + 8'd1;
            end
        end
    end

    // Sticky session error: overflow on the final address, or timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (session_start) begin
            err <= 1'b0;
        end else if ((accept && (waddr_q == 8'hFF) && !ld_last) || timeout) begin
            err <= 1'b1;
        end
    end

    // Next-state logic; done takes priority over timeout in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: if (load_end) state_d = S_RUN;
            S_RUN: begin
                if (core_done) begin
                    state_d = S_HALT;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads programs, emulates the core by driving
// pc and core_done, and checks the RAM contents through inst.
module tb_prog_loader;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

`ifdef CYCLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        ld_valid;
  logic [8:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [7:0]  pc;
  logic [8:0]  inst;
  logic        core_done;
  logic        core_reset;
  logic        busy;
  logic        finished;
  logic        err;
  logic [15:0] cycle_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] a_word;
  logic [8:0] b_word;

  prog_loader #(.MAX_CYCLES(16'd20)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .ld_ready(ld_ready),
    .pc(pc),
    .inst(inst),
    .core_done(core_done),
    .core_reset(core_reset),
    .busy(busy),
    .finished(finished),
    .err(err),
    .cycle_cnt(cycle_cnt),
    .dbg_state(dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] exp_cnt(input int n);
    return 16'(n) & {16{CNT_ON}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs and samples happen 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // one load beat: push the word to the expected queue when it is driven
  task automatic beat(input logic [8:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #1;
    chk("ld_ready_beat", ld_ready, 1'b1);
    exp_q.push_back(d);
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // read addresses 0..n-1 through pc and compare against the queue head
  task automatic read_back(input int n);
    for (int i = 0; i < n; i++) begin
      pc = 8'(i);
      #1;
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 32'd1, 32'd0);
      end else begin
        chk("inst_readback", inst, exp_q.pop_front());
      end
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] s);
    chk({tag, "_state"}, dbg_state, s);
    chk({tag, "_busy"}, busy, (s == S_LOAD) || (s == S_RUN));
    chk({tag, "_finished"}, finished, s == S_HALT);
    chk({tag, "_ld_ready"}, ld_ready, s == S_LOAD);
    chk({tag, "_core_reset"}, core_reset, s != S_RUN);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; ld_valid = 1'b0; ld_data = 9'd0;
    ld_last = 1'b0; pc = 8'd0; core_done = 1'b0;
    // reset wins over a simultaneous start
    steps(2);
    reset = 1'b0; start = 1'b0;
    chk_state("reset", S_IDLE);
    chk("reset_err", err, 1'b0);
    chk("reset_cnt", cycle_cnt, 16'd0);

    // three-beat program, last on the third beat
    pulse_start();
    chk_state("load1", S_LOAD);
    beat(9'h010, 1'b0);
    beat(9'h020, 1'b0);
    chk_state("load1_mid", S_LOAD);
    beat(9'h1FF, 1'b1);
    chk_state("run1", S_RUN);
    read_back(3);
    steps(2);
    // start in RUN is ignored
    pulse_start();
    chk_state("run1_start_ignored", S_RUN);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk_state("halt1", S_HALT);
    chk("halt1_cnt", cycle_cnt, exp_cnt(3));
    chk("halt1_err", err, 1'b0);
    steps(2);
    chk("halt1_cnt_hold", cycle_cnt, exp_cnt(3));

    // five-word program ending in halt, done after 12 RUN cycles
    pulse_start();
    chk_state("load2", S_LOAD);
    chk("load2_cnt_cleared", cycle_cnt, 16'd0);
    for (int i = 0; i < 4; i++) beat(9'($urandom_range(0, 510)), 1'b0);
    beat(9'h1FF, 1'b1);
    chk_state("run2", S_RUN);
    read_back(5);
    steps(12);
    chk("run2_cnt12", cycle_cnt, exp_cnt(12));
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk_state("halt2", S_HALT);
    chk("halt2_cnt", cycle_cnt, exp_cnt(12));
    chk("halt2_err", err, 1'b0);

    // 256 beats without ld_last: overflow ends the load with err
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      if (i < 255) chk("ovf_err_pending", err, 1'b0);
      beat(9'($urandom_range(0, 511)), 1'b0);
    end
    chk_state("ovf_run", S_RUN);
    chk("ovf_err", err, 1'b1);
    // a 257th beat is refused
    ld_valid = 1'b1; ld_data = 9'h0AA;
    #1;
    chk("ovf_257_ready", ld_ready, 1'b0);
    step();
    ld_valid = 1'b0;
    read_back(256);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk_state("ovf_halt", S_HALT);
    chk("ovf_err_hold", err, 1'b1);

    // looping program: timeout at the limit of 20 cycles
    pulse_start();
    chk("to_err_cleared", err, 1'b0);
    beat(9'h000, 1'b1);
    read_back(1);
    steps(20);
    chk_state("to_run20", S_RUN);
    chk("to_cnt20", cycle_cnt, exp_cnt(20));
    if (CNT_ON) begin
      step();
      chk_state("to_halt", S_HALT);
      chk("to_err", err, 1'b1);
      chk("to_cnt", cycle_cnt, 16'd20);
    end else begin
      // no counter: a long run never times out
      for (int i = 0; i < 10; i++) begin
        steps(10);
        chk_state("nocnt_run", S_RUN);
        chk("nocnt_cnt", cycle_cnt, 16'd0);
        chk("nocnt_err", err, 1'b0);
      end
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      chk_state("nocnt_halt", S_HALT);
    end

    // done exactly when the count reaches the limit: done wins
    pulse_start();
    beat(9'h000, 1'b1);
    read_back(1);
    steps(20);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk_state("dw_halt", S_HALT);
    chk("dw_err", err, 1'b0);
    chk("dw_cnt", cycle_cnt, exp_cnt(20));

    // reset mid-LOAD after two beats aborts, RAM retained
    pulse_start();
    a_word = 9'($urandom_range(0, 511));
    b_word = 9'($urandom_range(0, 511));
    beat(a_word, 1'b0);
    beat(b_word, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_state("abort", S_IDLE);
    chk("abort_err", err, 1'b0);
    chk("abort_cnt", cycle_cnt, 16'd0);
    read_back(2);
    // new session rewrites from address 0
    pulse_start();
    beat(9'h101, 1'b0);
    beat(9'h055, 1'b0);
    beat(9'h1FF, 1'b1);
    chk_state("reload_run", S_RUN);
    read_back(3);
    steps(4);
    // reset in RUN aborts too, and beats start over
    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    chk_state("abort_run", S_IDLE);
    chk("abort_run_cnt", cycle_cnt, 16'd0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
